ysyx_22040895_lsu_ctrl: RTL and testbench

- Multi-cycle load/store sequencer between the control unit's memory-control outputs (sl, munit, mwe) and a single-port 64-bit data-memory bus.
- Latches one access, drives an aligned bus request with a byte mask, waits for grant and response, and formats load data (sign/zero extension).
- Stalls the pipeline until the access completes, and reports misalignment and bus timeout.

---
 rtl/ysyx_22040895_lsu_ctrl_pkg.sv | 44 ++++
 rtl/ysyx_22040895_lsu_ctrl_fmt.sv | 59 +++++
 rtl/ysyx_22040895_lsu_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ysyx_22040895_lsu_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040895_lsu_ctrl_pkg.sv
// ysyx_22040895_lsu_ctrl_pkg
//   Shared encodings for the load/store sequencer: the control unit's sl and
//   munit fields, the sequencer FSM states, and a helper that gives the
//   unshifted byte-enable pattern for an access width.
package ysyx_22040895_lsu_ctrl_pkg;

  // Access kind coming from the control unit.
  typedef enum logic [1:0] {
    SL_NONE   = 2'b00,
    SL_STORE  = 2'b01,
    SL_LOAD_S = 2'b10,
    SL_LOAD_U = 2'b11
  } sl_e;

  // Access width coming from the control unit.
  typedef enum logic [1:0] {
    MU_B = 2'b00,
    MU_H = 2'b01,
    MU_W = 2'b10,
    MU_D = 2'b11
  } munit_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_RESP = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Byte enables for an access of the given width sitting in lane 0.
  function automatic logic [7:0] lane_mask(input logic [1:0] munit);
    logic [7:0] m;
    case (munit)
      MU_B:    m = 8'h01;
      MU_H:    m = 8'h03;
      MU_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_ctrl_fmt.sv
// ysyx_22040895_lsu_ctrl_fmt
//   Purely combinational byte-lane unit of the load/store sequencer.
//   Ports:
//     sl_i, munit_i   access kind and width
//     off_i           byte offset inside the doubleword (addr[2:0])
//     wdata_i         right-aligned store data
//     rdata_i         aligned doubleword returned by the bus
//     wmask_o         byte enables shifted to the addressed lanes
//     wdata_o         store data shifted to the addressed lanes
//     misalign_o      access does not sit on its natural boundary
//     rdata_o         load data moved to lane 0 and extended to 64 bits
module ysyx_22040895_lsu_fmt
  import ysyx_22040895_lsu_ctrl_pkg::*;
(
  input  logic [1:0]  sl_i,
  input  logic [1:0]  munit_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  wmask_o,
  output logic [63:0] wdata_o,
  output logic        misalign_o,
  output logic [63:0] rdata_o
);

  logic [63:0] shifted;
  logic        sign_ext;

  // Store path: both the enables and the data move up by the byte offset.
  always_comb begin
    wmask_o = lane_mask(munit_i) << off_i;
    wdata_o = wdata_i << {off_i, 3'b000};
  end

  // An access is misaligned when the offset is not a multiple of its size;
  // bytes can never be misaligned.
  always_comb begin
    case (munit_i)
      MU_H:    misalign_o = off_i[0];
      MU_W:    misalign_o = |off_i[1:0];
      MU_D:    misalign_o = |off_i;
      default: misalign_o = 1'b0;
    endcase
  end

  // Load path: bring the addressed bytes down to lane 0, then fill the upper
  // bits with either the sign bit or zeros. A doubleword has nothing to fill.
  always_comb begin
    shifted  = rdata_i >> {off_i, 3'b000};
    sign_ext = (sl_i == SL_LOAD_S);
    case (munit_i)
      MU_B:    rdata_o = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
      MU_H:    rdata_o = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
      MU_W:    rdata_o = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040895_lsu_ctrl.sv
// ysyx_22040895_lsu_ctrl
//   Multi-cycle load/store sequencer between the control unit and a
//   single-port 64-bit data memory bus. One access is latched in IDLE, a
//   doubleword-aligned request is held on the bus until granted, the response
//   is awaited, and the result is reported with a one-cycle done pulse.
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     req_valid_i, sl_i, munit_i,
//     addr_i, wdata_i                   access presented by the EX/MEM stage
//     stall_o                           hold the pipeline while the access runs
//     done_o, err_o, rdata_o            completion pulse, error flag, load data
//     mem_req_o, mem_we_o, mem_addr_o,
//     mem_wmask_o, mem_wdata_o          bus request side
//     mem_gnt_i, mem_rvalid_i,
//     mem_rdata_i                       bus grant and response side
module ysyx_22040895_lsu_ctrl
  import ysyx_22040895_lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [1:0]        sl_i,
  input  logic [1:0]        munit_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [63:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o,
  output logic [63:0]       rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wmask_o,
  output logic [63:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e              state_q, state_d;
  logic [1:0]          sl_q, sl_d;
  logic [1:0]          munit_q, munit_d;
  logic [2:0]          off_q, off_d;
  logic [ADDR_W-1:3]   addr_hi_q, addr_hi_d;
  logic [7:0]          wmask_q, wmask_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [63:0]         rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                idle;
  logic                accept;
  logic                timeout_hit;
  logic [CNT_W-1:0]    cnt_inc;
  logic [1:0]          fmt_munit;
  logic [2:0]          fmt_off;
  logic [7:0]          fmt_wmask;
  logic [63:0]         fmt_wdata;
  logic                fmt_misalign;
  logic [63:0]         fmt_rdata;

  // The formatter sees the live inputs while IDLE, so the misalign decision
  // and the shifted mask/data are ready to be latched in the accept cycle.
  // Afterwards it sees the latched access so the load extension in WAIT uses
  // the width and offset of the access in flight.
  always_comb begin
    idle      = (state_q == ST_IDLE);
    fmt_munit = idle ? munit_i : munit_q;
    fmt_off   = idle ? addr_i[2:0] : off_q;
  end

  ysyx_22040895_lsu_fmt u_fmt (
    .sl_i       (sl_q),
    .munit_i    (fmt_munit),
    .off_i      (fmt_off),
    .wdata_i    (wdata_i),
    .rdata_i    (mem_rdata_i),
    .wmask_o    (fmt_wmask),
    .wdata_o    (fmt_wdata),
    .misalign_o (fmt_misalign),
    .rdata_o    (fmt_rdata)
  );

  // State and access registers. Reset returns to IDLE and clears everything,
  // which also aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sl_q      <= SL_NONE;
      munit_q   <= MU_B;
      off_q     <= '0;
      addr_hi_q <= '0;
      wmask_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sl_q      <= sl_d;
      munit_q   <= munit_d;
      off_q     <= off_d;
      addr_hi_q <= addr_hi_d;
      wmask_q   <= wmask_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic. The timeout counter runs in REQ and WAIT and trips on
  // the TIMEOUT-th cycle spent there. A grant in REQ or a response in WAIT
  // always takes priority over the timeout, and responses are only honoured
  // in WAIT, so an rvalid arriving together with the grant is dropped.
  always_comb begin
    state_d     = state_q;
    sl_d        = sl_q;
    munit_d     = munit_q;
    off_d       = off_q;
    addr_hi_d   = addr_hi_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    accept      = req_valid_i && (sl_i != SL_NONE);
    timeout_hit = (TIMEOUT != 0) && (cnt_q >= CNT_LAST);
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          sl_d      = sl_i;
          munit_d   = munit_i;
          off_d     = addr_i[2:0];
          addr_hi_d = addr_i[ADDR_W-1:3];
          wmask_d   = fmt_wmask;
          wdata_d   = fmt_wdata;
          state_d   = fmt_misalign ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        if (mem_gnt_i) begin
          state_d = ST_WAIT;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_rvalid_i) begin
          rdata_d = (sl_q == SL_STORE) ? 64'd0 : fmt_rdata;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_RESP, ST_ERR: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs. Stall is combinational so the pipeline freezes in the accept
  // cycle, and it drops in RESP/ERR so the pipeline advances on the same edge
  // that returns the sequencer to IDLE. Bus outputs are zero outside REQ.
  always_comb begin
    stall_o     = req_valid_i && (sl_i != SL_NONE) &&
                  (state_q != ST_RESP) && (state_q != ST_ERR);
    done_o      = 1'b0;
    err_o       = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wmask_o = '0;
    mem_wdata_o = '0;
    case (state_q)
      ST_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = (sl_q == SL_STORE);
        mem_addr_o  = {addr_hi_q, 3'b000};
        mem_wmask_o = wmask_q;
        mem_wdata_o = (sl_q == SL_STORE) ? wdata_q : 64'd0;
      end
      ST_RESP: begin
        done_o  = 1'b1;
        rdata_o = rdata_q;
      end
      ST_ERR: begin
        done_o = 1'b1;
        err_o  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040895_lsu_ctrl.sv
// tb_ysyx_22040895_lsu_ctrl
//   Self-checking bench for the load/store sequencer. Stimulus tasks push the
//   expected completion (error flag and load result) into a queue; a monitor
//   pops and compares whenever done_o is seen. Bus-side outputs, stall and
//   latency are checked cycle by cycle against a reference computed from the
//   access rules with plain arithmetic.
module tb_ysyx_22040895_lsu_ctrl;

  localparam int TO = 8;
  localparam logic [1:0] K_STORE = 2'b01;
  localparam logic [1:0] K_LB    = 2'b10;
  localparam logic [1:0] K_LBU   = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [1:0]  sl_i;
  logic [1:0]  munit_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic [63:0] rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [7:0]  mem_wmask_o;
  logic [63:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  ysyx_22040895_lsu_ctrl #(.ADDR_W(64), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .sl_i         (sl_i),
    .munit_i      (munit_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .rdata_o      (rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wmask_o  (mem_wmask_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // One comparison: count it, and report it when it does not match.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: number of bytes an access of width mu covers.
  function automatic int refBytes(input logic [1:0] mu);
    return 1 << mu;
  endfunction

  // Reference: an access must start on a multiple of its own size.
  function automatic bit refMisaligned(input logic [1:0] mu, input logic [2:0] a);
    return (int'(a) % refBytes(mu)) != 0;
  endfunction

  // Reference: byte enables for width mu starting at byte a.
  function automatic logic [7:0] refMask(input logic [1:0] mu, input logic [2:0] a);
    logic [15:0] m;
    m = ((16'd1 << refBytes(mu)) - 16'd1) << a;
    return m[7:0];
  endfunction

  // Reference: pick the addressed bytes of the doubleword and extend them.
  function automatic logic [63:0] refLoad(input logic [1:0] sl, input logic [1:0] mu,
                                          input logic [2:0] a, input logic [63:0] bus);
    int          bits;
    logic [63:0] v;
    logic [63:0] keep;
    bits = 8 * refBytes(mu);
    v    = bus >> (8 * int'(a));
    if (bits < 64) begin
      keep = (64'd1 << bits) - 64'd1;
      v    = v & keep;
      if (sl == K_LB && v[bits-1]) v = v | ~keep;
    end
    return v;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done_o=1, expected no completion pending");
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("done_err", {63'd0, err_o}, {63'd0, mon_e.err});
        checkOutput("done_rdata", rdata_o, mon_e.rdata);
      end
    end
  end

  // Present one access and play the bus: grant after g refused REQ cycles,
  // response r cycles after the grant (none if norv). stray adds random
  // rvalid pulses during REQ, which must be ignored.
  task automatic applyStimulus(input logic [1:0] sl, input logic [1:0] mu,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input int g, input int r, input bit norv,
                               input bit stray, input logic [63:0] busdata);
    bit          mis;
    bit          seen;
    bit          exp_req;
    int          lat;
    logic [2:0]  a;
    exp_t        e;
    a   = addr[2:0];
    mis = refMisaligned(mu, a);
    if (mis) lat = 1;
    else if (norv) lat = TO + 1;
    else lat = g + r + 3;
    e.err   = mis | norv;
    e.rdata = (e.err || sl == K_STORE) ? 64'd0 : refLoad(sl, mu, a, busdata);

    @(posedge clk); #1;
    req_valid_i  = 1'b1;
    sl_i         = sl;
    munit_i      = mu;
    addr_i       = addr;
    wdata_i      = wdata;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    #1;
    checkOutput("stall_accept", {63'd0, stall_o}, 64'd1);
    exp_q.push_back(e);

    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      mem_gnt_i    = !mis && (k == g + 1);
      mem_rvalid_i = !mis && !norv && (k == g + r + 2);
      if (stray && !mis && k <= g + 1) mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_rdata_i  = (k == g + r + 2) ? busdata : {$urandom, $urandom};
      @(negedge clk);
      exp_req = !mis && (k <= g + 1);
      checkOutput("stall", {63'd0, stall_o}, {63'd0, (k < lat)});
      checkOutput("mem_req", {63'd0, mem_req_o}, {63'd0, exp_req});
      if (exp_req) begin
        checkOutput("mem_addr", mem_addr_o, {addr[63:3], 3'b000});
        checkOutput("mem_wmask", {56'd0, mem_wmask_o}, {56'd0, refMask(mu, a)});
        checkOutput("mem_we", {63'd0, mem_we_o}, {63'd0, (sl == K_STORE)});
        if (sl == K_STORE) checkOutput("mem_wdata", mem_wdata_o, wdata << (8 * int'(a)));
      end
      if (done_o === 1'b1) begin
        seen = 1'b1;
        checkOutput("latency", 64'(k), 64'(lat));
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL done_wait: got no done_o within 40 cycles, expected one after %0d", lat);
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  // Idle cycles with no access; optional stray grant/response noise.
  task automatic idleCycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid_i  = 1'($urandom_range(0, 1));
      sl_i         = 2'b00;
      mem_gnt_i    = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rvalid_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata_i  = {$urandom, $urandom};
      @(negedge clk);
      checkOutput("idle_stall", {63'd0, stall_o}, 64'd0);
      checkOutput("idle_done", {63'd0, done_o}, 64'd0);
      checkOutput("idle_req", {63'd0, mem_req_o}, 64'd0);
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  // Every output must be zero (inputs held quiet by the caller).
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stall"}, {63'd0, stall_o}, 64'd0);
    checkOutput({tag, "_done"}, {63'd0, done_o}, 64'd0);
    checkOutput({tag, "_err"}, {63'd0, err_o}, 64'd0);
    checkOutput({tag, "_rdata"}, rdata_o, 64'd0);
    checkOutput({tag, "_req"}, {63'd0, mem_req_o}, 64'd0);
    checkOutput({tag, "_we"}, {63'd0, mem_we_o}, 64'd0);
    checkOutput({tag, "_addr"}, mem_addr_o, 64'd0);
    checkOutput({tag, "_wmask"}, {56'd0, mem_wmask_o}, 64'd0);
    checkOutput({tag, "_wdata"}, mem_wdata_o, 64'd0);
  endtask

  // Reset while waiting for a response: the access is abandoned and a late
  // response must not produce a completion.
  task automatic resetInWait();
    @(posedge clk); #1;
    req_valid_i = 1'b1;
    sl_i        = K_LBU;
    munit_i     = 2'b11;
    addr_i      = 64'h0000_0000_0000_2000;
    @(posedge clk); #1;
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i   = 1'b0;
    rst         = 1'b1;
    req_valid_i = 1'b0;
    sl_i        = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("rst_wait");
    @(posedge clk); #1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 64'hDEAD_BEEF_0000_1111;
    @(negedge clk);
    checkOutput("rst_late_rvalid_done", {63'd0, done_o}, 64'd0);
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_after_done", {63'd0, done_o}, 64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed cases, then randomized accesses.
  initial begin
    rst          = 1'b1;
    req_valid_i  = 1'b0;
    sl_i         = 2'b00;
    munit_i      = 2'b00;
    addr_i       = '0;
    wdata_i      = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] store byte at offset 5");
    applyStimulus(K_STORE, 2'b00, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_00AB,
                  0, 0, 1'b0, 1'b0, 64'd0);

    $display("[TB] lb / lbu / lw extension");
    applyStimulus(K_LB,  2'b00, 64'h0000_0000_0000_1003, 64'd0, 0, 0, 1'b0, 1'b0,
                  64'h0000_0000_8000_0000);
    applyStimulus(K_LBU, 2'b00, 64'h0000_0000_0000_1003, 64'd0, 0, 0, 1'b0, 1'b0,
                  64'h0000_0000_8000_0000);
    applyStimulus(K_LB,  2'b10, 64'h0000_0000_0000_2004, 64'd0, 0, 0, 1'b0, 1'b0,
                  64'h8765_4321_0000_0000);

    $display("[TB] misaligned double store");
    applyStimulus(K_STORE, 2'b11, 64'h0000_0000_0000_1004, 64'h1122_3344_5566_7788,
                  0, 0, 1'b0, 1'b0, 64'd0);

    $display("[TB] grant delayed 5 cycles");
    applyStimulus(K_LBU, 2'b01, 64'h0000_0000_0000_4006, 64'd0, 5, 0, 1'b0, 1'b0,
                  64'hA5B6_0000_0000_0000);

    $display("[TB] timeout with no response, then stray rvalid");
    applyStimulus(K_LB, 2'b11, 64'h0000_0000_0000_3000, 64'd0, 0, 0, 1'b1, 1'b0, 64'd0);
    idleCycles(3, 1'b1);
    applyStimulus(K_LB, 2'b01, 64'h0000_0000_0000_3002, 64'd0, 1, 2, 1'b0, 1'b1,
                  64'h0000_0000_F00D_0000);

    $display("[TB] reset while waiting for response");
    resetInWait();

    $display("[TB] randomized accesses");
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  s;
      logic [1:0]  m;
      logic [63:0] ad;
      int          nb;
      s  = 2'($urandom_range(1, 3));
      m  = 2'($urandom_range(0, 3));
      nb = 1 << m;
      ad = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) ad[2:0] = ad[2:0] & 3'(~(nb - 1));
      applyStimulus(s, m, ad, {$urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                    {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) idleCycles(int'($urandom_range(1, 3)), $urandom_range(0, 1) == 1);
    end

    idleCycles(2, 1'b0);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL pending_completions: got %0d left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
